// File: rtl/demo_slave_if.sv
// Bus between the master-side demo driver and the slave-side demo responder.
// This bus carries single-beat read/write requests and their completion.
//   req_valid  : request strobe; the slave samples it only while ready=1
//   req_rw     : 1 = write, 0 = read
//   req_addr   : request address (device select field in the top bits)
//   req_wdata  : write data
//   ready      : slave is idle and can accept a request
//   resp_valid : one-cycle completion pulse
//   resp_rdata : read data, valid with resp_valid on a read
//   resp_err   : one-cycle pulse with resp_valid on a decode miss
interface demo_slave_if #(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 8
);
    logic                  req_valid;
    logic                  req_rw;
    logic [ADDR_WIDTH-1:0] req_addr;
    logic [DATA_WIDTH-1:0] req_wdata;
    logic                  ready;
    logic                  resp_valid;
    logic [DATA_WIDTH-1:0] resp_rdata;
    logic                  resp_err;

    modport master (
        output req_valid, req_rw, req_addr, req_wdata,
        input  ready, resp_valid, resp_rdata, resp_err
    );

    modport slave (
        input  req_valid, req_rw, req_addr, req_wdata,
        output ready, resp_valid, resp_rdata, resp_err
    );
endinterface

// File: rtl/demo_slave_responder.sv
// Slave-side demo device. It accepts single-beat read/write requests and decodes
// the device select field in the top address bits. After WAIT_CYCLES busy
// cycles it services a hit from a local byte memory. It then returns a
// one-cycle completion pulse, which carries an error flag on a decode miss.
// Ports:
//   clk       : clock, rising edge
//   rst       : asynchronous active-high reset
//   bus       : demo_slave_if slave modport (request in, ready/response out)
//   led       : last byte written to memory
//   txn_count : number of serviced hit requests, wraps 255 -> 0
module demo_slave_responder #(
    parameter int                         ADDR_WIDTH     = 16,
    parameter int                         DATA_WIDTH     = 8,
    parameter int                         MEM_ADDR_WIDTH = 12,
    parameter int                         DEV_SEL_WIDTH  = 4,
    parameter logic [DEV_SEL_WIDTH-1:0]   DEV_ID         = 4'b0100,
    parameter int unsigned                WAIT_CYCLES    = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    demo_slave_if.slave           bus,
    output logic [DATA_WIDTH-1:0] led,
    output logic [7:0]            txn_count
);
    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_WAIT   = 2'd1,
        S_ACCESS = 2'd2,
        S_RESP   = 2'd3
    } state_t;

    // Counter starts at WAIT_CYCLES-1 so that WAIT lasts exactly WAIT_CYCLES cycles.
    localparam logic [3:0] WAIT_LOAD = (WAIT_CYCLES > 32'd0) ? 4'(WAIT_CYCLES - 32'd1) : 4'd0;

    state_t                    state_r;
    state_t                    next_state_s;
    logic                      accept_s;
    logic                      rw_r;
    logic                      hit_r;
    logic [MEM_ADDR_WIDTH-1:0] offset_r;
    logic [DATA_WIDTH-1:0]     wdata_r;
    logic [3:0]                wait_cnt_r;
    logic [DATA_WIDTH-1:0]     rdata_r;
    logic [DATA_WIDTH-1:0]     led_r;
    logic [7:0]                txn_r;
    logic                      ready_r;
    logic                      resp_valid_r;
    logic                      resp_err_r;
    logic [DATA_WIDTH-1:0]     mem_r [0:(2**MEM_ADDR_WIDTH)-1];

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= S_IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Next-state decode and request acceptance
    always_comb begin
        next_state_s = state_r;
        accept_s     = 1'b0;
        case (state_r)
            S_IDLE: begin
                if (bus.req_valid) begin
                    accept_s     = 1'b1;
                    next_state_s = (WAIT_CYCLES == 32'd0) ? S_ACCESS : S_WAIT;
                end else begin
                    next_state_s = S_IDLE;
                end
            end
            S_WAIT: begin
                if (wait_cnt_r == 4'd0) begin
                    next_state_s = S_ACCESS;
                end else begin
                    next_state_s = S_WAIT;
                end
            end
            S_ACCESS: next_state_s = S_RESP;
            S_RESP:   next_state_s = S_IDLE;
            default:  next_state_s = S_IDLE;
        endcase
    end

    // Request capture, wait counter, access results and registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rw_r         <= 1'b0;
            hit_r        <= 1'b0;
            offset_r     <= {MEM_ADDR_WIDTH{1'b0}};
            wdata_r      <= {DATA_WIDTH{1'b0}};
            wait_cnt_r   <= 4'd0;
            rdata_r      <= {DATA_WIDTH{1'b0}};
            led_r        <= {DATA_WIDTH{1'b0}};
            txn_r        <= 8'd0;
            ready_r      <= 1'b1;
            resp_valid_r <= 1'b0;
            resp_err_r   <= 1'b0;
        end else begin
            if (accept_s) begin
                rw_r       <= bus.req_rw;
                hit_r      <= (bus.req_addr[ADDR_WIDTH-1 -: DEV_SEL_WIDTH] == DEV_ID);
                offset_r   <= bus.req_addr[MEM_ADDR_WIDTH-1:0];
                wdata_r    <= bus.req_wdata;
                wait_cnt_r <= WAIT_LOAD;
            end else if ((state_r == S_WAIT) && (wait_cnt_r != 4'd0)) begin
                wait_cnt_r <= wait_cnt_r - 4'd1;
            end
            if (state_r == S_ACCESS) begin
                if (rw_r && hit_r) begin
                    led_r <= wdata_r;
                end
                // A read miss returns zero; write responses leave rdata untouched.
                if (!rw_r) begin
                    rdata_r <= hit_r ? mem_r[offset_r] : {DATA_WIDTH{1'b0}};
                end
            end
            if ((state_r == S_RESP) && hit_r) begin
                txn_r <= txn_r + 8'd1;
            end
            ready_r      <= (next_state_s == S_IDLE);
            resp_valid_r <= (next_state_s == S_RESP);
            resp_err_r   <= (next_state_s == S_RESP) && !hit_r;
        end
    end

    // Local memory write; contents survive reset, and reset drops a write still pending
    always_ff @(posedge clk) begin
        if ((state_r == S_ACCESS) && rw_r && hit_r) begin
            mem_r[offset_r] <= wdata_r;
        end
    end

    assign bus.ready      = ready_r;
    assign bus.resp_valid = resp_valid_r;
    assign bus.resp_rdata = rdata_r;
    assign bus.resp_err   = resp_err_r;
    assign led            = led_r;
    assign txn_count      = txn_r;
endmodule

// File: tb/tb_demo_slave_responder.sv
// Testbench for demo_slave_responder. The main instance uses WAIT_CYCLES=2 and a
// second instance uses WAIT_CYCLES=0. A table of directed transactions is
// checked first, followed by hand-written multi-cycle sequences.
module tb_demo_slave_responder;
    logic       clk;
    logic       rst;
    logic [7:0] led2;
    logic [7:0] txn2;
    logic [7:0] led0;
    logic [7:0] txn0;
    int         pass_cnt;
    int         total_cnt;

    demo_slave_if bus2 ();
    demo_slave_if bus0 ();

    demo_slave_responder #(.WAIT_CYCLES(2)) dut2 (
        .clk(clk), .rst(rst), .bus(bus2), .led(led2), .txn_count(txn2)
    );

    demo_slave_responder #(.WAIT_CYCLES(0)) dut0 (
        .clk(clk), .rst(rst), .bus(bus0), .led(led0), .txn_count(txn0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rw;
        logic [15:0] addr;
        logic [7:0]  wdata;
        logic [7:0]  exp_rdata;
        logic        exp_err;
        logic [7:0]  exp_led;
        logic [7:0]  exp_txn;
    } vec_t;

    vec_t vecs [14];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) begin
            pass_cnt++;
        end else begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Issue one request on bus2 from a negedge; returns response data and accept-to-response edges.
    task automatic run_txn(input logic rw, input logic [15:0] addr, input logic [7:0] wdata,
                           output logic [7:0] rdata, output logic err, output int lat);
        int guard;
        guard = 0;
        while (!bus2.ready && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        check("ready_before_req", 32'(bus2.ready), 32'd1);
        bus2.req_valid = 1'b1;
        bus2.req_rw    = rw;
        bus2.req_addr  = addr;
        bus2.req_wdata = wdata;
        @(negedge clk);
        bus2.req_valid = 1'b0;
        lat = 0;
        while (!bus2.resp_valid && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        if (!bus2.resp_valid) lat = -1;
        rdata = bus2.resp_rdata;
        err   = bus2.resp_err;
        @(negedge clk);
        check("resp_one_cycle", 32'(bus2.resp_valid), 32'd0);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, expected finish before timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] rd;
        logic       er;
        int         lat;
        int         cnt;

        pass_cnt  = 0;
        total_cnt = 0;
        bus2.req_valid = 1'b0; bus2.req_rw = 1'b0; bus2.req_addr = 16'h0000; bus2.req_wdata = 8'h00;
        bus0.req_valid = 1'b0; bus0.req_rw = 1'b0; bus0.req_addr = 16'h0000; bus0.req_wdata = 8'h00;

        vecs[0]  = '{1'b1, 16'h4801, 8'hA5, 8'h00, 1'b0, 8'hA5, 8'd1};
        vecs[1]  = '{1'b0, 16'h4801, 8'h00, 8'hA5, 1'b0, 8'hA5, 8'd2};
        vecs[2]  = '{1'b1, 16'h5801, 8'h3C, 8'hA5, 1'b1, 8'hA5, 8'd2};
        vecs[3]  = '{1'b0, 16'h4801, 8'h00, 8'hA5, 1'b0, 8'hA5, 8'd3};
        vecs[4]  = '{1'b0, 16'h5801, 8'h00, 8'h00, 1'b1, 8'hA5, 8'd3};
        vecs[5]  = '{1'b1, 16'h4002, 8'hE7, 8'h00, 1'b0, 8'hE7, 8'd4};
        vecs[6]  = '{1'b0, 16'h4002, 8'h00, 8'hE7, 1'b0, 8'hE7, 8'd5};
        vecs[7]  = '{1'b1, 16'h4FFF, 8'h5A, 8'hE7, 1'b0, 8'h5A, 8'd6};
        vecs[8]  = '{1'b1, 16'h4000, 8'hC3, 8'hE7, 1'b0, 8'hC3, 8'd7};
        vecs[9]  = '{1'b0, 16'h4FFF, 8'h00, 8'h5A, 1'b0, 8'hC3, 8'd8};
        vecs[10] = '{1'b0, 16'h4000, 8'h00, 8'hC3, 1'b0, 8'hC3, 8'd9};
        vecs[11] = '{1'b1, 16'h4003, 8'h22, 8'hC3, 1'b0, 8'h22, 8'd10};
        vecs[12] = '{1'b1, 16'h0003, 8'h99, 8'hC3, 1'b1, 8'h22, 8'd10};
        vecs[13] = '{1'b0, 16'h4003, 8'h00, 8'h22, 1'b0, 8'h22, 8'd11};

        // Reset state
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("rst_ready",      32'(bus2.ready),      32'd1);
        check("rst_resp_valid", 32'(bus2.resp_valid), 32'd0);
        check("rst_resp_err",   32'(bus2.resp_err),   32'd0);
        check("rst_rdata",      32'(bus2.resp_rdata), 32'h00);
        check("rst_led",        32'(led2),            32'h00);
        check("rst_txn",        32'(txn2),            32'd0);
        rst = 1'b0;
        @(negedge clk);

        // Directed table
        for (int i = 0; i < 14; i++) begin
            run_txn(vecs[i].rw, vecs[i].addr, vecs[i].wdata, rd, er, lat);
            check($sformatf("v%0d_latency", i), 32'(lat), 32'd3);
            check($sformatf("v%0d_rdata", i),   32'(rd),  32'(vecs[i].exp_rdata));
            check($sformatf("v%0d_err", i),     32'(er),  32'(vecs[i].exp_err));
            check($sformatf("v%0d_led", i),     32'(led2), 32'(vecs[i].exp_led));
            check($sformatf("v%0d_txn", i),     32'(txn2), 32'(vecs[i].exp_txn));
        end

        // Request pulsed during WAIT is ignored: exactly one response
        bus2.req_valid = 1'b1; bus2.req_rw = 1'b1; bus2.req_addr = 16'h4005; bus2.req_wdata = 8'h66;
        @(negedge clk);
        bus2.req_valid = 1'b1; bus2.req_rw = 1'b0; bus2.req_addr = 16'h4801;
        @(negedge clk);
        bus2.req_valid = 1'b0;
        cnt = 0;
        for (int k = 0; k < 10; k++) begin
            if (bus2.resp_valid) cnt++;
            @(negedge clk);
        end
        check("wait_pulse_resp_count", 32'(cnt), 32'd1);
        check("wait_pulse_led", 32'(led2), 32'h66);
        check("wait_pulse_txn", 32'(txn2), 32'd12);

        // Back-to-back write then read, read issued during RESP and accepted on first IDLE cycle
        bus2.req_valid = 1'b1; bus2.req_rw = 1'b1; bus2.req_addr = 16'h4002; bus2.req_wdata = 8'h11;
        @(negedge clk);
        bus2.req_valid = 1'b0;
        cnt = 0;
        while (!bus2.resp_valid && cnt < 40) begin
            @(negedge clk);
            cnt++;
        end
        check("b2b_write_latency", 32'(cnt), 32'd3);
        bus2.req_valid = 1'b1; bus2.req_rw = 1'b0; bus2.req_addr = 16'h4002;
        @(negedge clk);
        check("b2b_idle_ready", 32'(bus2.ready), 32'd1);
        @(negedge clk);
        check("b2b_no_bubble", 32'(bus2.ready), 32'd0);
        bus2.req_valid = 1'b0;
        cnt = 0;
        while (!bus2.resp_valid && cnt < 40) begin
            @(negedge clk);
            cnt++;
        end
        check("b2b_read_latency", 32'(cnt), 32'd3);
        check("b2b_read_data", 32'(bus2.resp_rdata), 32'h11);
        @(negedge clk);
        check("b2b_led", 32'(led2), 32'h11);
        check("b2b_txn", 32'(txn2), 32'd14);

        // Reset during WAIT of a write aborts it
        bus2.req_valid = 1'b1; bus2.req_rw = 1'b1; bus2.req_addr = 16'h4003; bus2.req_wdata = 8'h77;
        @(negedge clk);
        bus2.req_valid = 1'b0;
        check("abort_in_wait", 32'(bus2.ready), 32'd0);
        rst = 1'b1;
        #1;
        check("abort_ready", 32'(bus2.ready),      32'd1);
        check("abort_valid", 32'(bus2.resp_valid), 32'd0);
        check("abort_rdata", 32'(bus2.resp_rdata), 32'h00);
        check("abort_led",   32'(led2),            32'h00);
        check("abort_txn",   32'(txn2),            32'd0);
        @(negedge clk);
        rst = 1'b0;
        cnt = 0;
        for (int k = 0; k < 8; k++) begin
            if (bus2.resp_valid) cnt++;
            @(negedge clk);
        end
        check("abort_no_resp", 32'(cnt), 32'd0);
        run_txn(1'b0, 16'h4003, 8'h00, rd, er, lat);
        check("abort_read_old", 32'(rd),   32'h22);
        check("abort_read_lat", 32'(lat),  32'd3);
        check("abort_read_txn", 32'(txn2), 32'd1);

        // 256 hit writes wrap txn_count
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 256; i++) begin
            run_txn(1'b1, 16'h4100 + 16'(i), 8'(i), rd, er, lat);
            if (i == 254) check("wrap_txn_255", 32'(txn2), 32'd255);
        end
        check("wrap_txn_0", 32'(txn2), 32'd0);
        check("wrap_led",   32'(led2), 32'hFF);

        // Zero-wait instance: one edge from accept to response
        bus0.req_valid = 1'b1; bus0.req_rw = 1'b1; bus0.req_addr = 16'h4801; bus0.req_wdata = 8'hA5;
        @(negedge clk);
        bus0.req_valid = 1'b0;
        cnt = 0;
        while (!bus0.resp_valid && cnt < 40) begin
            @(negedge clk);
            cnt++;
        end
        check("w0_write_latency", 32'(cnt), 32'd1);
        check("w0_write_err", 32'(bus0.resp_err), 32'd0);
        @(negedge clk);
        check("w0_pulse_end", 32'(bus0.resp_valid), 32'd0);
        check("w0_ready", 32'(bus0.ready), 32'd1);
        check("w0_led", 32'(led0), 32'hA5);
        check("w0_txn", 32'(txn0), 32'd1);
        bus0.req_valid = 1'b1; bus0.req_rw = 1'b0; bus0.req_addr = 16'h4801;
        @(negedge clk);
        bus0.req_valid = 1'b0;
        cnt = 0;
        while (!bus0.resp_valid && cnt < 40) begin
            @(negedge clk);
            cnt++;
        end
        check("w0_read_latency", 32'(cnt), 32'd1);
        check("w0_read_data", 32'(bus0.resp_rdata), 32'hA5);
        @(negedge clk);
        check("w0_read_txn", 32'(txn0), 32'd2);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
